// File: rtl/unidade_de_busca_if.sv
// Bundle of the fetch unit's instruction-memory request bus and its decode-side handshake.
// master is the fetch unit's view; slave is the memory/decode side.
interface unidade_de_busca_if;
    logic        mem_req;
    logic [31:0] mem_end;
    logic        mem_ack;
    logic [31:0] mem_dado;
    logic        instr_valida;
    logic [31:0] instrucao;
    logic [31:0] pc_instr;
    logic        instr_pronta;
    logic        desvio;
    logic [31:0] alvo_desvio;

    modport master (
        output mem_req, mem_end, instr_valida, instrucao, pc_instr,
        input  mem_ack, mem_dado, instr_pronta, desvio, alvo_desvio
    );

    modport slave (
        input  mem_req, mem_end, instr_valida, instrucao, pc_instr,
        output mem_ack, mem_dado, instr_pronta, desvio, alvo_desvio
    );
endinterface

// File: rtl/unidade_de_busca.sv
// Instruction fetch stage: issues word requests to instruction memory, buffers the returned
// words in a circular prefetch queue and hands them to decode; redirects flush everything.
module unidade_de_busca #(
    parameter int          PROF_FILA = 2,
    parameter logic [31:0] PC_RESET  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    unidade_de_busca_if.master    bus
);

    localparam int PTR_W = (PROF_FILA > 1) ? $clog2(PROF_FILA) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CAPACIDADE = CNT_W'(PROF_FILA);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        DESCARTE = 2'd2
    } estado_t;

    estado_t           estado_q,  estado_d;
    logic [31:0]       pc_busca_q, pc_busca_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_end_q, mem_end_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;

    logic [31:0]       fila_instr_q [PROF_FILA];
    logic [31:0]       fila_pc_q    [PROF_FILA];

    logic              push;
    logic              pop;
    logic              ack;
    logic [31:0]       alvo;
    logic [31:0]       end_seguinte;
    logic [CNT_W-1:0]  count_pos_pop;
    logic [CNT_W-1:0]  count_com_push;

    // An ack with no request outstanding is a protocol error and must not touch any state.
    assign ack            = mem_req_q & bus.mem_ack;
    assign pop            = (count_q != '0) & bus.instr_pronta;
    assign alvo           = {bus.alvo_desvio[31:2], 2'b00};
    assign end_seguinte   = mem_end_q + 32'd4;
    assign count_pos_pop  = count_q - CNT_W'(pop);
    assign count_com_push = count_pos_pop + CNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        estado_d   = estado_q;
        pc_busca_d = pc_busca_q;
        mem_req_d  = mem_req_q;
        mem_end_d  = mem_end_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;

        if (bus.desvio) begin
            // A same-edge pop already delivered its word; the flush then discards the rest.
            pc_busca_d = alvo;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            unique case (estado_q)
                OCIOSO: begin
                    mem_req_d = 1'b1;
                    mem_end_d = alvo;
                    estado_d  = ESPERA;
                end
                ESPERA, DESCARTE: begin
                    if (ack) begin
                        mem_end_d = alvo;
                        estado_d  = ESPERA;
                    end else begin
                        estado_d  = DESCARTE;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_pos_pop;
            unique case (estado_q)
                OCIOSO: begin
                    if (count_q < CAPACIDADE) begin
                        mem_req_d = 1'b1;
                        mem_end_d = pc_busca_q;
                        estado_d  = ESPERA;
                    end
                end
                ESPERA: begin
                    if (ack) begin
                        push       = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                        count_d    = count_com_push;
                        pc_busca_d = end_seguinte;
                        // Back-to-back issue only while the new request still has a slot reserved.
                        if (count_com_push < CAPACIDADE) begin
                            mem_end_d = end_seguinte;
                        end else begin
                            mem_req_d = 1'b0;
                            estado_d  = OCIOSO;
                        end
                    end
                end
                DESCARTE: begin
                    if (ack) begin
                        mem_end_d = pc_busca_q;
                        estado_d  = ESPERA;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            pc_busca_q <= PC_RESET;
            mem_req_q  <= 1'b0;
            mem_end_q  <= PC_RESET;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            pc_busca_q <= pc_busca_d;
            mem_req_q  <= mem_req_d;
            mem_end_q  <= mem_end_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fila_instr_q[wr_ptr_q] <= bus.mem_dado;
            fila_pc_q[wr_ptr_q]    <= mem_end_q;
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_end      = mem_end_q;
    assign bus.instr_valida = (count_q != '0);
    assign bus.instrucao    = (count_q != '0) ? fila_instr_q[rd_ptr_q] : 32'h0;
    assign bus.pc_instr     = (count_q != '0) ? fila_pc_q[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench for unidade_de_busca: variable-latency memory, a transaction-level queue
// model checked every cycle, and hand-computed expectations for the fetch scenarios.
module tb_unidade_de_busca;

    localparam int          PROF   = 2;
    localparam logic [31:0] PC_RST = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entrada_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unidade_de_busca_if bus ();

    unidade_de_busca #(
        .PROF_FILA (PROF),
        .PC_RESET  (PC_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 1;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [31:0] palavra(input logic [31:0] a);
        return 32'hA5A5_0000 ^ {a[15:0], a[15:0]};
    endfunction

    // Memory: acks the lat-th cycle of each request, data is a fixed function of the address.
    int espera_cnt = 0;
    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_dado = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.mem_req) begin
                bus.mem_ack = 1'b0;
                espera_cnt  = 0;
            end else begin
                if (bus.mem_ack) espera_cnt = 1;
                else             espera_cnt++;
                bus.mem_ack = (espera_cnt >= lat);
            end
            bus.mem_dado = palavra(bus.mem_end);
        end
    end

    // Reference model: the queue contents as a list of accepted words, plus the fetch stream.
    entrada_t    fila_m[$];
    logic [31:0] exp_fetch = PC_RST;
    logic        stale     = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] end_prev  = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valida",    {31'b0, bus.instr_valida}, 32'h0);
            check("rst_req",       {31'b0, bus.mem_req},      32'h0);
            check("rst_instrucao", bus.instrucao,             32'h0);
            check("rst_end",       bus.mem_end,               PC_RST);
            fila_m.delete();
            exp_fetch = PC_RST;
            stale     = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("m_valida", {31'b0, bus.instr_valida}, {31'b0, fila_m.size() != 0});
            if (fila_m.size() != 0) begin
                check("m_pc",    bus.pc_instr,  fila_m[0].pc);
                check("m_instr", bus.instrucao, fila_m[0].instr);
            end else begin
                check("m_instr_vazia", bus.instrucao, 32'h0);
            end
            if (hold_prev) begin
                check("m_req_mantido", {31'b0, bus.mem_req}, 32'h1);
                check("m_end_mantido", bus.mem_end, end_prev);
            end
            if (bus.mem_req) begin
                check("m_end_alinhado", {30'b0, bus.mem_end[1:0]}, 32'h0);
                check("m_ocupacao", {31'b0, fila_m.size() < PROF}, 32'h1);
            end

            if (fila_m.size() != 0 && bus.instr_pronta) void'(fila_m.pop_front());
            if (bus.mem_req && bus.mem_ack) begin
                if (!stale && !bus.desvio) begin
                    check("m_end_sequencia", bus.mem_end, exp_fetch);
                    fila_m.push_back('{bus.mem_end, bus.mem_dado});
                    exp_fetch = exp_fetch + 32'd4;
                end
                stale = 1'b0;
            end
            if (bus.desvio) begin
                fila_m.delete();
                exp_fetch = {bus.alvo_desvio[31:2], 2'b00};
                stale     = bus.mem_req && !bus.mem_ack;
            end
            hold_prev = bus.mem_req && !bus.mem_ack;
            end_prev  = bus.mem_end;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.instr_pronta = 1'b0;
        bus.desvio       = 1'b0;
        bus.alvo_desvio  = 32'h0;

        // T1: zero-wait memory, consumer always ready.
        lat = 1;
        bus.instr_pronta = 1'b1;
        apply_reset();
        cyc();
        check("t1_req",    {31'b0, bus.mem_req},      32'h1);
        check("t1_end",    bus.mem_end,               32'h0);
        check("t1_valida", {31'b0, bus.instr_valida}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t1_valida_seq", {31'b0, bus.instr_valida}, 32'h1);
            check("t1_pc_seq",     bus.pc_instr,              32'(i * 4));
        end

        // T2: stalled consumer fills the queue, then release.
        bus.instr_pronta = 1'b0;
        apply_reset();
        repeat (3) cyc();
        check("t2_cheia_pc",  bus.pc_instr,         32'h0);
        check("t2_cheia_req", {31'b0, bus.mem_req}, 32'h0);
        repeat (2) cyc();
        check("t2_req_parado", {31'b0, bus.mem_req}, 32'h0);
        bus.instr_pronta = 1'b1;
        cyc();
        check("t2_pc4",     bus.pc_instr,         32'h4);
        check("t2_req_ain", {31'b0, bus.mem_req}, 32'h0);
        cyc();
        check("t2_req8",     {31'b0, bus.mem_req},      32'h1);
        check("t2_end8",     bus.mem_end,               32'h8);
        check("t2_vazia",    {31'b0, bus.instr_valida}, 32'h0);
        cyc();
        check("t2_pc8",    bus.pc_instr,  32'h8);
        check("t2_instr8", bus.instrucao, 32'hA5AD_0008);

        // T3: three-cycle memory latency.
        lat = 3;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_end0_mantido", bus.mem_end,               32'h0);
            check("t3_valida_ini",   {31'b0, bus.instr_valida}, 32'h0);
        end
        cyc();
        check("t3_pc0",    bus.pc_instr,  32'h0);
        check("t3_instr0", bus.instrucao, 32'hA5A5_0000);
        check("t3_end4",   bus.mem_end,   32'h4);
        cyc();
        check("t3_pulso_a", {31'b0, bus.instr_valida}, 32'h0);
        cyc();
        check("t3_pulso_b", {31'b0, bus.instr_valida}, 32'h0);
        cyc();
        check("t3_pc4", bus.pc_instr, 32'h4);
        check("t3_end8", bus.mem_end, 32'h8);

        // T4: redirect while the request to 8 is outstanding.
        bus.desvio      = 1'b1;
        bus.alvo_desvio = 32'h40;
        cyc();
        bus.desvio = 1'b0;
        check("t4_end8_mantido", bus.mem_end,               32'h8);
        check("t4_vazia",        {31'b0, bus.instr_valida}, 32'h0);
        cyc();
        cyc();
        check("t4_end40", bus.mem_end,               32'h40);
        check("t4_nada",  {31'b0, bus.instr_valida}, 32'h0);
        repeat (3) cyc();
        check("t4_pc40",    bus.pc_instr,  32'h40);
        check("t4_instr40", bus.instrucao, 32'hA5E5_0040);

        // T5: redirect on the same edge as a transfer and an ack; unaligned target.
        lat = 1;
        apply_reset();
        repeat (2) cyc();
        check("t5_pc0", bus.pc_instr, 32'h0);
        cyc();
        check("t5_pc4", bus.pc_instr, 32'h4);
        check("t5_end8", bus.mem_end, 32'h8);
        bus.desvio      = 1'b1;
        bus.alvo_desvio = 32'h43;
        cyc();
        bus.desvio = 1'b0;
        check("t5_vazia", {31'b0, bus.instr_valida}, 32'h0);
        check("t5_end40", bus.mem_end,               32'h40);
        check("t5_req",   {31'b0, bus.mem_req},      32'h1);
        cyc();
        check("t5_pc40", bus.pc_instr, 32'h40);

        // T6: asynchronous reset in the middle of a request.
        bus.instr_pronta = 1'b0;
        apply_reset();
        repeat (2) cyc();
        check("t6_valida_antes", {31'b0, bus.instr_valida}, 32'h1);
        check("t6_req_antes",    {31'b0, bus.mem_req},      32'h1);
        rst = 1'b1;
        #1;
        check("t6_req_async",    {31'b0, bus.mem_req},      32'h0);
        check("t6_valida_async", {31'b0, bus.instr_valida}, 32'h0);
        check("t6_end_async",    bus.mem_end,               PC_RST);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        check("t6_req_refetch", {31'b0, bus.mem_req}, 32'h1);
        check("t6_end_refetch", bus.mem_end,          PC_RST);
        cyc();
        check("t6_pc_refetch", bus.pc_instr, PC_RST);

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
